// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the shared register-file write port, with a busy-bit
// scoreboard of destinations awaiting writeback for decode hazard detection.
module regfile_wb_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*ADDR_W-1:0] src_rd,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_rd,
  input  logic                      flush,
  input  logic [ADDR_W-1:0]         rs1_addr,
  input  logic [ADDR_W-1:0]         rs2_addr,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  output logic                      rf_wr_en,
  output logic [ADDR_W-1:0]         rf_rd,
  output logic [DATA_W-1:0]         rf_result
);

  localparam int PTR_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int NUM_REGS = 1 << ADDR_W;
  localparam logic [PTR_W-1:0] LAST_SRC = PTR_W'(NUM_SRC - 1);

  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    gnt_idx;
  logic [PTR_W-1:0]    idx;
  logic                grant_any;
  logic [NUM_SRC-1:0]  grant;
  logic [ADDR_W-1:0]   sel_rd;
  logic [DATA_W-1:0]   sel_data;
  logic                wr_fire;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;

  // Search from ptr upward, wrapping; the first valid source wins.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    grant     = '0;
    gnt_idx   = '0;
    idx       = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = PTR_W'((int'(ptr) + k) % NUM_SRC);
      if (!grant_any && !rst && src_valid[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

  assign src_ready = grant;
  assign sel_rd    = src_rd[gnt_idx*ADDR_W +: ADDR_W];
  assign sel_data  = src_data[gnt_idx*DATA_W +: DATA_W];
  // A transfer to x0 is accepted but never reaches the register file.
  assign wr_fire   = grant_any && (sel_rd != '0);

  // Later updates override earlier ones, so a same-cycle issue beats both flush and writeback.
  always_comb begin
    busy_next = busy;
    if (flush)
      busy_next = '0;
    if (wr_fire)
      busy_next[sel_rd] = 1'b0;
    if (issue_valid && (issue_rd != '0))
      busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  assign rs1_busy = busy[rs1_addr];
  assign rs2_busy = busy[rs2_addr];

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      ptr       <= '0;
      // NOTE: the scoreboard is a flop vector, not a RAM, so it can and must be reset.
      busy      <= '0;
      rf_wr_en  <= 1'b0;
      rf_rd     <= '0;
      rf_result <= '0;
    end else begin
      if (grant_any)
        ptr <= (gnt_idx == LAST_SRC) ? '0 : gnt_idx + 1'b1;
      rf_wr_en <= wr_fire;
      if (wr_fire) begin
        rf_rd     <= sel_rd;
        rf_result <= sel_data;
      end
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a vector table for arbitration, write port
// and hazards, plus hand-written sequences for flush and reset corner cases.
module tb_regfile_wb_arbiter;

  localparam logic [31:0] D0 = 32'h1111_0000;
  localparam logic [31:0] D1 = 32'hDEAD_BEEF;
  localparam logic [31:0] D2 = 32'h2222_0002;

  logic        clk;
  logic        rst;
  logic [2:0]  src_valid;
  logic [2:0]  src_ready;
  logic [14:0] src_rd;
  logic [95:0] src_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        flush;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        rf_wr_en;
  logic [4:0]  rf_rd;
  logic [31:0] rf_result;

  logic [31:0] rf_mem [32];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  valid;
    logic [4:0]  rd0, rd1, rd2;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  rs1, rs2;
    logic [2:0]  exp_ready;
    logic        exp_wr;
    logic [4:0]  exp_rd;
    logic [31:0] exp_res;
    logic        exp_b1, exp_b2;
  } vec_t;

  vec_t vecs[20];

  regfile_wb_arbiter #(.NUM_SRC(3), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_ready(src_ready), .src_rd(src_rd), .src_data(src_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_wr_en(rf_wr_en), .rf_rd(rf_rd), .rf_result(rf_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model commits on the negedge inside the write cycle.
  always @(negedge clk)
    if (rf_wr_en) rf_mem[rf_rd] <= rf_result;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            valid  rd0 rd1 rd2 iv ird rs1 rs2 ready  wr rd res    b1 b2
    vecs[0]  = '{3'b010, 0, 5, 0, 0, 0,  5, 0, 3'b010, 0, 0, 32'h0, 0, 0};
    vecs[1]  = '{3'b000, 0, 0, 0, 0, 0,  5, 0, 3'b000, 1, 5, D1,    0, 0};
    vecs[2]  = '{3'b000, 0, 0, 0, 0, 0,  5, 0, 3'b000, 0, 5, D1,    0, 0};
    vecs[3]  = '{3'b111, 1, 2, 3, 0, 0,  1, 2, 3'b100, 0, 5, D1,    0, 0};
    vecs[4]  = '{3'b111, 1, 2, 3, 0, 0,  1, 2, 3'b001, 1, 3, D2,    0, 0};
    vecs[5]  = '{3'b111, 1, 2, 3, 0, 0,  1, 2, 3'b010, 1, 1, D0,    0, 0};
    vecs[6]  = '{3'b111, 1, 2, 3, 0, 0,  1, 2, 3'b100, 1, 2, D1,    0, 0};
    vecs[7]  = '{3'b111, 1, 2, 3, 0, 0,  1, 2, 3'b001, 1, 3, D2,    0, 0};
    vecs[8]  = '{3'b111, 1, 2, 3, 0, 0,  1, 2, 3'b010, 1, 1, D0,    0, 0};
    vecs[9]  = '{3'b111, 1, 2, 3, 0, 0,  1, 2, 3'b100, 1, 2, D1,    0, 0};
    vecs[10] = '{3'b000, 0, 0, 0, 0, 0,  1, 2, 3'b000, 1, 3, D2,    0, 0};
    vecs[11] = '{3'b000, 0, 0, 0, 1, 7,  7, 7, 3'b000, 0, 3, D2,    0, 0};
    vecs[12] = '{3'b000, 0, 0, 0, 0, 0,  7, 7, 3'b000, 0, 3, D2,    1, 1};
    vecs[13] = '{3'b001, 7, 0, 0, 0, 0,  7, 0, 3'b001, 0, 3, D2,    1, 0};
    vecs[14] = '{3'b000, 0, 0, 0, 0, 0,  7, 7, 3'b000, 1, 7, D0,    0, 0};
    vecs[15] = '{3'b010, 0, 0, 0, 0, 0,  0, 0, 3'b010, 0, 7, D0,    0, 0};
    vecs[16] = '{3'b000, 0, 0, 0, 0, 0,  0, 0, 3'b000, 0, 7, D0,    0, 0};
    vecs[17] = '{3'b000, 0, 0, 0, 1, 9,  9, 0, 3'b000, 0, 7, D0,    0, 0};
    vecs[18] = '{3'b100, 0, 0, 9, 1, 9,  9, 0, 3'b100, 0, 7, D0,    1, 0};
    vecs[19] = '{3'b000, 0, 0, 0, 0, 0,  9, 0, 3'b000, 1, 9, D2,    1, 0};

    src_data    = {D2, D1, D0};
    src_valid   = 3'b111;
    src_rd      = {5'd3, 5'd2, 5'd1};
    issue_valid = 1'b0;
    issue_rd    = '0;
    flush       = 1'b0;
    rs1_addr    = 5'd7;
    rs2_addr    = 5'd0;
    rst         = 1'b1;

    // Reset held two cycles with every source requesting.
    for (int c = 0; c < 2; c++) begin
      step();
      check($sformatf("reset%0d ready", c), 32'(src_ready), 32'h0);
      check($sformatf("reset%0d wr_en", c), 32'(rf_wr_en), 32'h0);
      check($sformatf("reset%0d rs1_busy", c), 32'(rs1_busy), 32'h0);
    end
    rst = 1'b0;
    #1;
    check("post-reset ready", 32'(src_ready), 32'h1);
    check("post-reset rf_rd", 32'(rf_rd), 32'h0);
    check("post-reset rf_result", rf_result, 32'h0);
    src_valid = 3'b000;
    step();

    for (int i = 0; i < 20; i++) begin
      src_valid   = vecs[i].valid;
      src_rd      = {vecs[i].rd2, vecs[i].rd1, vecs[i].rd0};
      issue_valid = vecs[i].iv;
      issue_rd    = vecs[i].ird;
      rs1_addr    = vecs[i].rs1;
      rs2_addr    = vecs[i].rs2;
      #1;
      check($sformatf("v%0d ready", i), 32'(src_ready), 32'(vecs[i].exp_ready));
      check($sformatf("v%0d wr_en", i), 32'(rf_wr_en), 32'(vecs[i].exp_wr));
      check($sformatf("v%0d rf_rd", i), 32'(rf_rd), 32'(vecs[i].exp_rd));
      check($sformatf("v%0d rf_result", i), rf_result, vecs[i].exp_res);
      check($sformatf("v%0d rs1_busy", i), 32'(rs1_busy), 32'(vecs[i].exp_b1));
      check($sformatf("v%0d rs2_busy", i), 32'(rs2_busy), 32'(vecs[i].exp_b2));
      step();
    end
    src_valid   = 3'b000;
    issue_valid = 1'b0;

    @(negedge clk);
    #1;
    check("regfile x7", rf_mem[7], D0);
    check("regfile x9", rf_mem[9], D2);
    step();

    // Build busy {3,4,9}, then flush together with an issue of x12.
    issue_valid = 1'b1;
    issue_rd    = 5'd3;
    rs1_addr    = 5'd9;
    #1;
    check("pre-flush busy9", 32'(rs1_busy), 32'h1);
    step();
    issue_rd = 5'd4;
    step();
    issue_valid = 1'b0;
    rs1_addr    = 5'd3;
    rs2_addr    = 5'd4;
    #1;
    check("pre-flush busy3", 32'(rs1_busy), 32'h1);
    check("pre-flush busy4", 32'(rs2_busy), 32'h1);
    flush       = 1'b1;
    issue_valid = 1'b1;
    issue_rd    = 5'd12;
    step();
    flush       = 1'b0;
    issue_valid = 1'b0;
    #1;
    check("flush busy3", 32'(rs1_busy), 32'h0);
    check("flush busy4", 32'(rs2_busy), 32'h0);
    rs1_addr = 5'd12;
    rs2_addr = 5'd9;
    #1;
    check("flush busy12", 32'(rs1_busy), 32'h1);
    check("flush busy9", 32'(rs2_busy), 32'h0);

    // Transfer from src0 moves ptr to 1; reset during the next transfer cycle discards it.
    src_valid = 3'b001;
    src_rd    = {5'd0, 5'd11, 5'd10};
    #1;
    check("pre-rst ready", 32'(src_ready), 32'h1);
    step();
    src_valid = 3'b010;
    rst       = 1'b1;
    #1;
    check("mid-rst ready", 32'(src_ready), 32'h0);
    check("mid-rst wr_en", 32'(rf_wr_en), 32'h1);
    check("mid-rst rf_rd", 32'(rf_rd), 32'd10);
    step();
    rst       = 1'b0;
    src_valid = 3'b000;
    #1;
    check("after-rst wr_en", 32'(rf_wr_en), 32'h0);
    check("after-rst rf_rd", 32'(rf_rd), 32'h0);
    check("after-rst rf_result", rf_result, 32'h0);
    check("after-rst busy12", 32'(rs1_busy), 32'h0);
    src_valid = 3'b101;
    #1;
    check("after-rst ptr0 ready", 32'(src_ready), 32'h1);
    src_valid = 3'b000;
    step();
    check("after-rst no pulse", 32'(rf_wr_en), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
